// File: rtl/isram_axil_rd.sv
// Instruction SRAM behind an AXI4-Lite read channel (AR/R only), one outstanding read.
// Word-addressed memory with a side preload port, configurable read wait states.
module isram_axil_rd #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          RD_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic        init_we,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_wdata
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (RD_LATENCY == 0) ? 4'd0 : 4'(RD_LATENCY - 1);
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;
  localparam logic [1:0]  DECERR   = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  rsp_t        rsp_q;
  logic        cap;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero latency the capture happens on the accept edge, before addr_q holds the address.
  logic [31:0]   cap_addr;
  logic [32:0]   cap_off;
  logic          cap_inr;
  logic [AW-1:0] cap_idx;
  logic [1:0]    cap_resp;

  assign cap_addr = (state_q == IDLE) ? araddr : addr_q;
  assign cap_off  = {1'b0, cap_addr} - {1'b0, BASE_ADDR};
  assign cap_inr  = !cap_off[32] && (cap_off < SPAN);
  assign cap_idx  = cap_off[AW+1:2];

  always_comb begin
    cap_resp = OKAY;
    if (!cap_inr)                  cap_resp = DECERR;
    else if (cap_addr[1:0] != 2'b00) cap_resp = SLVERR;
  end

  logic [32:0]   init_off;
  logic          init_ok;
  logic [AW-1:0] init_idx;

  assign init_off = {1'b0, init_addr} - {1'b0, BASE_ADDR};
  assign init_ok  = !init_off[32] && (init_off < SPAN) && (init_addr[1:0] == 2'b00);
  assign init_idx = init_off[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: if (arvalid) begin
        if (RD_LATENCY == 0) begin
          state_d = RESP;
          cap     = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d = RESP;
        cap     = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && arvalid) addr_q <= araddr;
      // Nonblocking read sees pre-write contents when a preload hits the same word.
      if (cap) begin
        rsp_q.resp <= cap_resp;
        rsp_q.data <= (cap_resp == OKAY) ? mem[cap_idx] : 32'h0;
      end
    end
  end

  // Contents survive reset; preload stays live while rst is high.
  always_ff @(posedge clk) begin
    if (init_we && init_ok) mem[init_idx] <= init_wdata;
  end

  assign arready = (state_q == IDLE);
  assign rvalid  = (state_q == RESP);
  assign rdata   = rsp_q.data;
  assign rresp   = rsp_q.resp;

endmodule
